lsu_ctrl: RTL

- Load/store initiator that sits between the core's execute stage and the byte-addressed data RAM.
- Accepts one CPU request at a time through a valid/ready handshake and drives the RAM's write strobe, ctrl (funct3), address and wData.
- Captures the RAM's combinational rData, sign- or zero-extends it, and returns a one-cycle response.
- Also handles range checking and, optionally, splitting misaligned accesses into byte accesses.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_extend.sv | 22 ++
 rtl/lsu_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, FSM states
// and request-decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B      = 3'b000;
    localparam logic [2:0] F3_H      = 3'b001;
    localparam logic [2:0] F3_W      = 3'b010;
    localparam logic [2:0] F3_BU     = 3'b100;
    localparam logic [2:0] F3_HU     = 3'b101;
    localparam logic [2:0] CTRL_IDLE = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Access size in bytes (1, 2 or 4) from the low funct3 bits.
    function automatic logic [2:0] accessSize(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores only take signed codes; loads additionally take BU/HU.
    function automatic logic isLegal(input logic write, input logic [2:0] funct3);
        if (write)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            return (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
                   (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of a raw little-endian word according to funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] ext_o
);

    // Select the low byte/half and extend it; words pass through.
    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            F3_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_BU:   ext_o = {24'b0, raw_i[7:0]};
            F3_HU:   ext_o = {16'b0, raw_i[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and a byte-addressed RAM.
// Optional feature macro: MISALIGN_SPLIT_EN -- when defined, misaligned
// in-range accesses are split into sequential byte accesses; otherwise they
// are rejected with respErr.
//
// state  | meaning
// IDLE   | reqReady=1, waiting for a request
// ACCESS | single aligned RAM access (bus held idle for rejected requests)
// SPLIT  | one byte of a misaligned access per cycle
// RESP   | one-cycle response strobe
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 32
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [2:0]  reqFunct3,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    output logic [31:0] respRData,
    output logic        respErr,
    output logic        writeRam,
    output logic [2:0]  ctrl,
    output logic [31:0] address,
    output logic [31:0] wData,
    input  logic [31:0] rData
);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
`ifdef MISALIGN_SPLIT_EN
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  lat_size_m1;
`endif

    logic [2:0]  req_size;
    logic [2:0]  req_size_m1;
    logic [32:0] req_last;
    logic        req_oob;
    logic        req_misaligned;
    logic        req_legal;
    logic        req_reject;
    logic [31:0] ext_data;

    // Decode the incoming request; range is checked at 33 bits so it cannot wrap.
    always_comb begin
        req_size       = accessSize(reqFunct3);
        req_size_m1    = req_size - 3'd1;
        req_last       = {1'b0, reqAddr} + {30'b0, req_size_m1};
        req_oob        = req_last > 33'(DEPTH_BYTES - 1);
        req_misaligned = |(reqAddr[1:0] & req_size_m1[1:0]);
        req_legal      = isLegal(reqWrite, reqFunct3);
`ifdef MISALIGN_SPLIT_EN
        req_reject     = !req_legal || req_oob;
`else
        req_reject     = !req_legal || req_oob || req_misaligned;
`endif
    end

    lsu_extend u_extend (
        .raw_i    (result_q),
        .funct3_i (funct3_q),
        .ext_o    (ext_data)
    );

    // State and request registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            idx_q    <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef MISALIGN_SPLIT_EN
            idx_q    <= idx_d;
`endif
        end
    end

    // Next-state logic. Rejected requests still pass through ACCESS (with the
    // RAM bus idle) so every non-split response has the same 2-cycle latency.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        data_d   = data_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef MISALIGN_SPLIT_EN
        idx_d       = idx_q;
        lat_size_m1 = accessSize(funct3_q) - 3'd1;
`endif
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    write_d  = reqWrite;
                    funct3_d = reqFunct3;
                    addr_d   = reqAddr;
                    data_d   = reqWData;
                    result_d = '0;
                    err_d    = req_reject;
                    state_d  = ACCESS;
`ifdef MISALIGN_SPLIT_EN
                    if (!req_reject && req_misaligned) begin
                        state_d = SPLIT;
                        idx_d   = 2'd0;
                    end
`endif
                end
            end
            ACCESS: begin
                if (!err_q)
                    result_d = rData;
                state_d = RESP;
            end
`ifdef MISALIGN_SPLIT_EN
            SPLIT: begin
                result_d[8*idx_q +: 8] = rData[7:0];
                idx_d = idx_q + 2'd1;
                if ({1'b0, idx_q} == lat_size_m1)
                    state_d = RESP;
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; the RAM bus is idle outside ACCESS/SPLIT.
    always_comb begin
        reqReady  = (state_q == IDLE);
        respValid = 1'b0;
        respErr   = 1'b0;
        respRData = '0;
        writeRam  = 1'b0;
        ctrl      = CTRL_IDLE;
        address   = '0;
        wData     = '0;
        case (state_q)
            ACCESS: begin
                if (!err_q) begin
                    writeRam = write_q;
                    ctrl     = funct3_q;
                    address  = addr_q;
                    wData    = data_q;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            SPLIT: begin
                writeRam = write_q;
                ctrl     = write_q ? F3_B : F3_BU;
                address  = addr_q + {30'b0, idx_q};
                wData    = {24'b0, data_q[8*idx_q +: 8]};
            end
`endif
            RESP: begin
                respValid = 1'b1;
                respErr   = err_q;
                respRData = (err_q || write_q) ? 32'b0 : ext_data;
            end
            default: begin
            end
        endcase
    end

endmodule
